// File: rtl/inst_mem_responder.sv
// -----------------------------------------------------------------------------
// inst_mem_responder
//
// Responder side of the instruction-memory request/grant/valid handshake.
// Word fetches are granted while fewer than OUTSTANDING transactions are
// granted-but-not-popped. The program memory is read at the accept edge, and
// the result travels through a fixed-length pipeline into a first-word-fall-
// through response queue, so responses come back in request order. A separate
// program-write port loads the memory at boot or under test.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   inst_req_i     fetch request
//   inst_addr_i    fetch byte address (word index = addr[ADDR-1:2])
//   inst_grnt_o    request accepted this cycle (combinational)
//   inst_valid_o   response available at the head of the queue
//   inst_data_o    response data, forced to 0 for error responses
//   inst_err_o     response error (misaligned / out of range)
//   inst_rready_i  consumer accepts the head response
//   prog_we_i      program-memory write enable
//   prog_addr_i    program write byte address
//   prog_data_i    program write data
// -----------------------------------------------------------------------------
module inst_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR        = 32,
  parameter int DEPTH       = 1024,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inst_req_i,
  input  logic [ADDR-1:0]       inst_addr_i,
  output logic                  inst_grnt_o,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_data_o,
  output logic                  inst_err_o,
  input  logic                  inst_rready_i,
  input  logic                  prog_we_i,
  input  logic [ADDR-1:0]       prog_addr_i,
  input  logic [DATA_WIDTH-1:0] prog_data_i
);

  localparam int IW = ADDR - 2;                                // word-index width
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;         // memory index width
  localparam int CW = $clog2(OUTSTANDING + 1);                 // outstanding counter width
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;  // queue pointer width

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [IW-1:0] fetch_idx;
  logic [IW-1:0] prog_idx;
  logic          fetch_err;
  logic          prog_ok;

  assign fetch_idx = inst_addr_i[ADDR-1:2];
  assign prog_idx  = prog_addr_i[ADDR-1:2];
  assign fetch_err = (inst_addr_i[1:0] != 2'b00) || (fetch_idx >= IW'(DEPTH));
  assign prog_ok   = (prog_addr_i[1:0] == 2'b00) && (prog_idx < IW'(DEPTH));

  // ---------------------------------------------------------------------------
  // Grant / outstanding count
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic          pop;

  // The count covers pipeline entries as well as queued ones, which is what
  // keeps the response queue from ever overflowing.
  assign inst_grnt_o = inst_req_i & ~rst_i & (cnt_reg < CW'(OUTSTANDING));
  assign accept      = inst_req_i & inst_grnt_o;

  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !pop) begin
      cnt_next = cnt_reg + 1'b1;
    end else if (!accept && pop) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Program memory and data pipeline
  //
  // Stage 0 data is the registered memory read, so the memory maps onto block
  // RAM with its output register. A write and a read of the same word on one
  // edge return the old contents (read-first). Error entries skip the read;
  // their stage data is a don't-care because the output forces it to zero.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data_reg [LATENCY];
  logic [LATENCY-1:0]    pipe_valid_reg;
  logic [LATENCY-1:0]    pipe_err_reg;

  always_ff @(posedge clk_i) begin
    if (prog_we_i && prog_ok) begin
      mem[prog_idx[MW-1:0]] <= prog_data_i;
    end
    if (accept && !fetch_err) begin
      pipe_data_reg[0] <= mem[fetch_idx[MW-1:0]];
    end
    for (int k = 1; k < LATENCY; k++) begin
      pipe_data_reg[k] <= pipe_data_reg[k-1];
    end
  end

  // Control bits shift unconditionally; nothing downstream can stall them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid_reg <= '0;
      pipe_err_reg   <= '0;
    end else begin
      pipe_valid_reg[0] <= accept;
      pipe_err_reg[0]   <= fetch_err;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_valid_reg[k] <= pipe_valid_reg[k-1];
        pipe_err_reg[k]   <= pipe_err_reg[k-1];
      end
    end
  end

  logic                  last_valid;
  logic                  last_err;
  logic [DATA_WIDTH-1:0] last_data;

  assign last_valid = pipe_valid_reg[LATENCY-1];
  assign last_err   = pipe_err_reg[LATENCY-1];
  assign last_data  = pipe_data_reg[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Response queue (first-word-fall-through)
  //
  // When the queue is empty the final pipeline stage is presented directly at
  // the output; that bypass is what makes the response visible LATENCY cycles
  // after the grant. A bypassed entry popped in the same cycle is never
  // written into the queue.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] q_data_reg [OUTSTANDING];
  logic [OUTSTANDING-1:0] q_err_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         rd_ptr_next;
  logic [CW-1:0]         q_cnt_reg;
  logic [CW-1:0]         q_cnt_next;
  logic                  q_empty;
  logic                  q_push;
  logic                  q_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    ptr_inc = (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_empty = (q_cnt_reg == '0);
  assign q_pop   = pop & ~q_empty;
  assign q_push  = last_valid & ~(q_empty & pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    q_cnt_next  = q_cnt_reg;
    if (q_push) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    if (q_pop) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    if (q_push && !q_pop) begin
      q_cnt_next = q_cnt_reg + 1'b1;
    end else if (!q_push && q_pop) begin
      q_cnt_next = q_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (q_push) begin
      q_data_reg[wr_ptr_reg] <= last_data;
      q_err_reg[wr_ptr_reg]  <= last_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      q_cnt_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      q_cnt_reg  <= q_cnt_next;
      cnt_reg    <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output head
  // ---------------------------------------------------------------------------
  logic                  head_valid;
  logic                  head_err;
  logic [DATA_WIDTH-1:0] head_data;

  assign head_valid = ~q_empty | last_valid;
  assign head_err   = q_empty ? last_err  : q_err_reg[rd_ptr_reg];
  assign head_data  = q_empty ? last_data : q_data_reg[rd_ptr_reg];

  // Held low during reset so nothing can be popped while state is cleared.
  assign inst_valid_o = head_valid & ~rst_i;
  assign inst_err_o   = inst_valid_o & head_err;
  assign inst_data_o  = (inst_valid_o && !head_err) ? head_data : '0;
  assign pop          = inst_valid_o & inst_rready_i;

endmodule

// File: tb/tb_inst_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_responder
//
// Directed testbench for inst_mem_responder with default parameters
// (LATENCY=2, OUTSTANDING=4, DEPTH=1024). Inputs change 1 time unit after the
// rising edge; outputs are sampled 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_inst_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic        inst_grnt_o;
  logic        inst_valid_o;
  logic [31:0] inst_data_o;
  logic        inst_err_o;
  logic        inst_rready_i;
  logic        prog_we_i;
  logic [31:0] prog_addr_i;
  logic [31:0] prog_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  inst_mem_responder #(
    .DATA_WIDTH (32),
    .ADDR       (32),
    .DEPTH      (1024),
    .LATENCY    (2),
    .OUTSTANDING(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inst_req_i   (inst_req_i),
    .inst_addr_i  (inst_addr_i),
    .inst_grnt_o  (inst_grnt_o),
    .inst_valid_o (inst_valid_o),
    .inst_data_o  (inst_data_o),
    .inst_err_o   (inst_err_o),
    .inst_rready_i(inst_rready_i),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_data_i  (prog_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic prog_write(input logic [31:0] addr, input logic [31:0] data);
    prog_we_i   = 1'b1;
    prog_addr_i = addr;
    prog_data_i = data;
    step();
    prog_we_i   = 1'b0;
    $display("prog write addr=%h data=%h", addr, data);
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    inst_req_i  = 1'b1;
    inst_addr_i = 32'h0;
    step();
    #1;
    n_checks++;
    if (inst_grnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_grnt: got %b expected 0", inst_grnt_o); end
    n_checks++;
    if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    n_checks++;
    if (inst_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", inst_data_o); end
    n_checks++;
    if (inst_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", inst_err_o); end
    $display("reset: grnt=%b valid=%b data=%h err=%b", inst_grnt_o, inst_valid_o, inst_data_o, inst_err_o);
    step();
    rst_i      = 1'b0;
    inst_req_i = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    inst_rready_i = 1'b1;
    inst_req_i    = 1'b1;
    inst_addr_i   = 32'h10;
    #1;
    n_checks++;
    if (inst_grnt_o !== 1'b1) begin n_fail++; $display("FAIL single_grnt: got %b expected 1", inst_grnt_o); end
    step();
    inst_req_i = 1'b0;
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", inst_valid_o); end
    step();
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", inst_valid_o); end
    n_checks++;
    if (inst_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h expected deadbeef", inst_data_o); end
    n_checks++;
    if (inst_err_o !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", inst_err_o); end
    $display("single read addr=10 data=%h err=%b", inst_data_o, inst_err_o);
    step();
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", inst_valid_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    inst_rready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      inst_req_i  = (c < 4);
      inst_addr_i = 32'(4 * c);
      #1;
      if (c < 4) begin
        n_checks++;
        if (inst_grnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_grnt[%0d]: got %b expected 1", c, inst_grnt_o); end
      end
      exp_v = (c >= 2) && (c < 6);
      n_checks++;
      if (inst_valid_o !== exp_v) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, inst_valid_o, exp_v); end
      if (exp_v) begin
        n_checks++;
        if (inst_data_o !== 32'(c - 1)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, inst_data_o, 32'(c - 1)); end
      end
      $display("b2b cycle %0d: grnt=%b valid=%b data=%h", c, inst_grnt_o, inst_valid_o, inst_data_o);
      step();
    end
    inst_req_i = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h2;
    exp_d[1] = 32'h3;
    exp_d[2] = 32'h4;
    exp_d[3] = 32'hDEADBEEF;
    inst_rready_i = 1'b0;
    inst_req_i    = 1'b1;
    for (int c = 0; c < 6; c++) begin
      inst_addr_i = 32'(4 * c);
      #1;
      n_checks++;
      if (inst_grnt_o !== (c < 4)) begin n_fail++; $display("FAIL bp_grnt[%0d]: got %b expected %b", c, inst_grnt_o, (c < 4)); end
      if (c >= 2) begin
        n_checks++;
        if (inst_valid_o !== 1'b1 || inst_data_o !== 32'h1) begin
          n_fail++; $display("FAIL bp_head[%0d]: got valid=%b data=%h expected valid=1 data=1", c, inst_valid_o, inst_data_o);
        end
      end
      $display("bp cycle %0d: grnt=%b valid=%b data=%h", c, inst_grnt_o, inst_valid_o, inst_data_o);
      step();
    end
    // One pop; count is still full in this cycle, so no grant yet.
    inst_rready_i = 1'b1;
    inst_addr_i   = 32'h10;
    #1;
    n_checks++;
    if (inst_grnt_o !== 1'b0) begin n_fail++; $display("FAIL bp_pop_grnt: got %b expected 0", inst_grnt_o); end
    n_checks++;
    if (inst_valid_o !== 1'b1 || inst_data_o !== 32'h1) begin
      n_fail++; $display("FAIL bp_pop_data: got valid=%b data=%h expected valid=1 data=1", inst_valid_o, inst_data_o);
    end
    step();
    inst_rready_i = 1'b0;
    #1;
    n_checks++;
    if (inst_grnt_o !== 1'b1) begin n_fail++; $display("FAIL bp_regrant: got %b expected 1", inst_grnt_o); end
    n_checks++;
    if (inst_data_o !== 32'h2) begin n_fail++; $display("FAIL bp_next_head: got %h expected 2", inst_data_o); end
    $display("bp regrant: grnt=%b head=%h", inst_grnt_o, inst_data_o);
    step();
    inst_req_i    = 1'b0;
    inst_rready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (inst_valid_o !== 1'b1 || inst_data_o !== exp_d[c]) begin
        n_fail++; $display("FAIL bp_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", c, inst_valid_o, inst_data_o, exp_d[c]);
      end
      $display("bp drain %0d: data=%h", c, inst_data_o);
      step();
    end
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", inst_valid_o); end
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic        errs  [3];
    logic [31:0] datas [3];
    addrs[0] = 32'h2;    errs[0] = 1'b1; datas[0] = 32'h0;
    addrs[1] = 32'h1000; errs[1] = 1'b1; datas[1] = 32'h0;
    addrs[2] = 32'h10;   errs[2] = 1'b0; datas[2] = 32'hDEADBEEF;
    inst_rready_i = 1'b1;
    for (int v = 0; v < 3; v++) begin
      inst_req_i  = 1'b1;
      inst_addr_i = addrs[v];
      #1;
      n_checks++;
      if (inst_grnt_o !== 1'b1) begin n_fail++; $display("FAIL err_grnt[%0d]: got %b expected 1", v, inst_grnt_o); end
      step();
      inst_req_i = 1'b0;
      step();
      #1;
      n_checks++;
      if (inst_valid_o !== 1'b1 || inst_err_o !== errs[v] || inst_data_o !== datas[v]) begin
        n_fail++;
        $display("FAIL err_resp[%0d]: got valid=%b err=%b data=%h expected valid=1 err=%b data=%h",
                 v, inst_valid_o, inst_err_o, inst_data_o, errs[v], datas[v]);
      end
      $display("err read addr=%h: err=%b data=%h", addrs[v], inst_err_o, inst_data_o);
      step();
    end
  endtask

  task automatic test_write_collision();
    inst_rready_i = 1'b1;
    prog_we_i     = 1'b1;
    prog_addr_i   = 32'h20;
    prog_data_i   = 32'hA5A5A5A5;
    inst_req_i    = 1'b1;
    inst_addr_i   = 32'h20;
    #1;
    n_checks++;
    if (inst_grnt_o !== 1'b1) begin n_fail++; $display("FAIL coll_grnt: got %b expected 1", inst_grnt_o); end
    step();
    prog_we_i  = 1'b0;
    inst_req_i = 1'b0;
    step();
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b1 || inst_data_o !== 32'h11111111) begin
      n_fail++; $display("FAIL coll_old: got valid=%b data=%h expected valid=1 data=11111111", inst_valid_o, inst_data_o);
    end
    $display("collision read addr=20: data=%h", inst_data_o);
    step();
    // Misaligned and out-of-range writes (the latter aliases word 8 if unchecked).
    prog_write(32'h22, 32'hBAD0BAD0);
    prog_write(32'h1020, 32'hBAD1BAD1);
    inst_req_i  = 1'b1;
    inst_addr_i = 32'h20;
    step();
    inst_req_i = 1'b0;
    step();
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b1 || inst_data_o !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL coll_new: got valid=%b data=%h expected valid=1 data=a5a5a5a5", inst_valid_o, inst_data_o);
    end
    $display("reread addr=20: data=%h", inst_data_o);
    step();
  endtask

  task automatic test_reset_mid();
    inst_rready_i = 1'b0;
    inst_req_i    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      inst_addr_i = 32'(4 * c);
      #1;
      n_checks++;
      if (inst_grnt_o !== 1'b1) begin n_fail++; $display("FAIL rmid_grnt[%0d]: got %b expected 1", c, inst_grnt_o); end
      step();
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (inst_grnt_o !== 1'b0 || inst_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rmid_in_reset: got grnt=%b valid=%b expected 0 0", inst_grnt_o, inst_valid_o);
    end
    step();
    rst_i         = 1'b0;
    inst_req_i    = 1'b0;
    inst_rready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_stale[%0d]: got %b expected 0", c, inst_valid_o); end
      step();
    end
    // Count restarted at zero: exactly OUTSTANDING grants again.
    inst_rready_i = 1'b0;
    inst_req_i    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      inst_addr_i = 32'(4 * c);
      #1;
      n_checks++;
      if (inst_grnt_o !== (c < 4)) begin n_fail++; $display("FAIL rmid_regrant[%0d]: got %b expected %b", c, inst_grnt_o, (c < 4)); end
      step();
    end
    inst_req_i    = 1'b0;
    inst_rready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (inst_valid_o !== 1'b1 || inst_data_o !== 32'(c + 1)) begin
        n_fail++; $display("FAIL rmid_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", c, inst_valid_o, inst_data_o, 32'(c + 1));
      end
      $display("after reset drain %0d: data=%h", c, inst_data_o);
      step();
    end
    #1;
    n_checks++;
    if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_empty: got %b expected 0", inst_valid_o); end
    step();
  endtask

  initial begin
    rst_i         = 1'b1;
    inst_req_i    = 1'b0;
    inst_addr_i   = 32'h0;
    inst_rready_i = 1'b0;
    prog_we_i     = 1'b0;
    prog_addr_i   = 32'h0;
    prog_data_i   = 32'h0;

    test_reset();

    prog_write(32'h0,  32'h1);
    prog_write(32'h4,  32'h2);
    prog_write(32'h8,  32'h3);
    prog_write(32'hC,  32'h4);
    prog_write(32'h10, 32'hDEADBEEF);
    prog_write(32'h20, 32'h11111111);

    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_write_collision();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
